// File: rtl/accel_pkg.sv
// Shared sizing defaults and the lane packing helper for the tilt filter.
package accel_pkg;

  localparam int NCH        = 2;  // accelerometer channels
  localparam int DW         = 9;  // sample width, two's complement
  localparam int LOG2_DEPTH = 3;  // averaging window is 2^LOG2_DEPTH samples
  localparam int STEPW      = 4;  // step width, two's complement

  // LSB position of lane 'lane' in a packed vector of 'w'-bit lanes.
  // Only ever evaluated at elaboration time.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/accel_avg_ch.sv
// One channel: circular window buffer, running sum, registered average and
// the dead-zoned, clamped motion step derived from that average.
module accel_avg_ch
  import accel_pkg::*;
#(
  parameter int DW         = accel_pkg::DW,
  parameter int LOG2_DEPTH = accel_pkg::LOG2_DEPTH,
  parameter int DEADZONE   = 16,
  parameter int SHIFT      = 2,
  parameter int STEPW      = accel_pkg::STEPW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accept,
  input  logic                    load_step,
  input  logic [LOG2_DEPTH-1:0]   wptr,
  input  logic signed [DW-1:0]    sample,
  output logic signed [DW-1:0]    filt,
  output logic signed [STEPW-1:0] step
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = DW + LOG2_DEPTH;
  localparam logic [DW:0] DZ   = (DW+1)'(DEADZONE);
  localparam logic [DW:0] MAXS = (DW+1)'((1 << (STEPW-1)) - 1);

  logic signed [DW-1:0] ring_q [DEPTH];
  logic signed [SW-1:0] sum_q, sum_nxt;
  logic signed [DW:0]   fext;
  logic [DW:0]          mag, over, mag_step;
  logic signed [STEPW-1:0] step_nxt;

  // Running sum: add the newcomer, drop the sample it overwrites.
  always_comb begin
    sum_nxt = sum_q + SW'(sample) - SW'(ring_q[wptr]);
  end

  // Step from the registered average; |filt| at DW+1 bits so the most
  // negative sample cannot overflow, and the clamp keeps the step symmetric.
  always_comb begin
    fext     = (DW+1)'(filt);
    mag      = fext[DW] ? $unsigned(-fext) : $unsigned(fext);
    over     = (mag - DZ) >> SHIFT;
    mag_step = '0;
    if (mag > DZ) mag_step = (over > MAXS) ? MAXS : over;
    step_nxt = fext[DW] ? -STEPW'(mag_step) : STEPW'(mag_step);
  end

  // Window state, average and step registers; clear flushes like reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q <= '0;
      filt  <= '0;
      step  <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      sum_q <= '0;
      filt  <= '0;
      step  <= '0;
    end else begin
      if (accept) begin
        ring_q[wptr] <= sample;
        sum_q        <= sum_nxt;
        filt         <= DW'(sum_nxt >>> LOG2_DEPTH);
      end
      if (load_step) step <= step_nxt;
    end
  end

endmodule

// File: rtl/accel_tilt_filter.sv
// Multi-channel accelerometer window averager with a periodic motion step.
// Holds the shared write pointer, fill counter and step tick counter.
module accel_tilt_filter
  import accel_pkg::*;
#(
  parameter int NCH        = accel_pkg::NCH,
  parameter int DW         = accel_pkg::DW,
  parameter int LOG2_DEPTH = accel_pkg::LOG2_DEPTH,
  parameter int DEADZONE   = 16,
  parameter int SHIFT      = 2,
  parameter int STEPW      = accel_pkg::STEPW,
  parameter int TICK_DIV   = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NCH*DW-1:0]    sample_in,
  input  logic                 sample_valid,
  output logic [NCH*DW-1:0]    filt_out,
  output logic                 filt_valid,
  output logic [NCH*STEPW-1:0] step_out,
  output logic                 step_valid
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int TW    = $clog2(TICK_DIV + 1);

  logic [LOG2_DEPTH-1:0] wptr_q;
  logic [LOG2_DEPTH:0]   fill_q;
  logic [TW-1:0]         tick_q;
  logic                  accept, tick_tc, load_step;

  assign accept     = sample_valid & enable & ~clear;
  assign tick_tc    = enable & (tick_q == TW'(TICK_DIV - 1));
  assign filt_valid = (fill_q == (LOG2_DEPTH+1)'(DEPTH));
  // The step samples the pre-accept average, so filt_valid here is also pre-accept.
  assign load_step  = tick_tc & filt_valid & ~clear;

  // Shared pointer, saturating fill count, tick divider and step strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      fill_q     <= '0;
      tick_q     <= '0;
      step_valid <= 1'b0;
    end else if (clear) begin
      wptr_q     <= '0;
      fill_q     <= '0;
      tick_q     <= '0;
      step_valid <= 1'b0;
    end else begin
      if (accept) begin
        wptr_q <= wptr_q + 1'b1;
        if (!filt_valid) fill_q <= fill_q + 1'b1;
      end
      if (enable) tick_q <= tick_tc ? '0 : tick_q + 1'b1;
      step_valid <= load_step;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    accel_avg_ch #(
      .DW(DW), .LOG2_DEPTH(LOG2_DEPTH), .DEADZONE(DEADZONE),
      .SHIFT(SHIFT), .STEPW(STEPW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .accept    (accept),
      .load_step (load_step),
      .wptr      (wptr_q),
      .sample    (sample_in[lane_lsb(c, DW) +: DW]),
      .filt      (filt_out[lane_lsb(c, DW) +: DW]),
      .step      (step_out[lane_lsb(c, STEPW) +: STEPW])
    );
  end

endmodule

// File: doc/accel_tilt_filter.md
ACCEL_TILT_FILTER -- requirements
Module: accel_tilt_filter

Interface
REQ-001 Parameter NCH, default 2: number of accelerometer channels (X, Y, ...).
REQ-002 Parameter DW, default 9: sample width, two's complement.
REQ-003 Parameter LOG2_DEPTH, default 3: averaging window of DEPTH = 2^LOG2_DEPTH samples.
REQ-004 Parameter DEADZONE, default 16: magnitude at or below which a channel's step is 0.
REQ-005 Parameter SHIFT, default 2: right shift applied to the magnitude above DEADZONE.
REQ-006 Parameter STEPW, default 4: step width, two's complement.
REQ-007 Parameter TICK_DIV, default 1000000: clk cycles per step tick (100 Hz at 100 MHz).
REQ-008 clk  in  1  system clock; the only clock.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  high: accept samples and run the tick counter.
REQ-011 clear  in  1  synchronous flush of all filter state.
REQ-012 sample_in  in  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW].
REQ-013 sample_valid  in  1  one-cycle strobe qualifying sample_in.
REQ-014 filt_out  out  NCH*DW  per-channel window average, packed as sample_in.
REQ-015 filt_valid  out  1  high once DEPTH samples have been accepted since reset or clear.
REQ-016 step_out  out  NCH*STEPW  per-channel signed motion step, packed.
REQ-017 step_valid  out  1  one-cycle pulse when step_out is updated.

Function
REQ-018 A sample is accepted on any cycle with sample_valid=1, enable=1 and clear=0.
REQ-019 Each channel has a DEPTH-entry circular buffer and a running sum of DW+LOG2_DEPTH bits; on accept: sum <= sum + new - buf[wptr], buf[wptr] <= new.
REQ-020 A shared wptr increments on accept and wraps from DEPTH-1 to 0.
REQ-021 filt_out = sum >>> LOG2_DEPTH (arithmetic shift), registered; it reflects an accepted sample on the cycle after the accept.
REQ-022 A fill counter saturates at DEPTH; filt_valid asserts in the same cycle filt_out first reflects the DEPTH-th sample.
REQ-023 Tick counter counts 0..TICK_DIV-1 while enable=1, holds while enable=0, and wraps to 0 at its terminal count.
REQ-024 At terminal count with filt_valid=1, step_out loads and step_valid pulses for one cycle; with filt_valid=0, step_out holds and step_valid stays 0.
REQ-025 Step per channel: m = |filt|; m <= DEADZONE gives 0; otherwise sign(filt) * min((m-DEADZONE) >> SHIFT, 2^(STEPW-1)-1). The result is symmetric, so -2^(STEPW-1) never occurs.
REQ-026 |filt| is computed at DW+1 bits, so -2^(DW-1) does not overflow.
REQ-027 If tick and accept coincide, the step uses the registered filt_out of that cycle, i.e. the value before the accept.
REQ-028 clear=1 in one cycle zeroes buffers, sums, wptr, the fill counter, the tick counter, filt_out, filt_valid and step_out; clear has priority over sample_valid.
REQ-029 enable=0 ignores samples and forces step_valid=0; all other state is retained.

Reset
REQ-030 reset=0 asynchronously zeroes every register: outputs, buffers, sums, pointers and counters.
REQ-031 The first accept after reset release is treated as sample 1 of DEPTH.

Structure
REQ-032 NCH, DW, LOG2_DEPTH, STEPW and the packing-index helper belong in the shared package accel_pkg.
REQ-033 The sub-module accel_avg_ch (buffer, sum, average, step) is instantiated NCH times via generate; the top level holds wptr, the fill counter and the tick counter.
REQ-034 The design contains no dividers or multipliers; all arithmetic is shifts, adds and compares.

Verification (default parameters, TICK_DIV=10)
REQ-035 Reset asserted with random inputs -> all outputs 0; release then 7 accepts -> filt_valid=0 and no step_valid pulses.
REQ-036 8 accepts of X=+100, Y=-100 -> next cycle filt_out X=100, Y=-100, filt_valid=1; next tick step X=+7, Y=-7 (21 clamped).
REQ-037 Dead zone: X=+16 gives step 0, X=+17 gives 0, X=+20 gives +1, X=-20 gives -1.
REQ-038 Wrap: 8 accepts of 64 then 8 of 0 -> filt_out 56, 48, ..., 0, one per accept; X=-256 x8 -> filt_out -256, step -7.
REQ-039 Tick and accept on the same cycle -> step_out reflects the pre-accept filt_out.
REQ-040 Mid-window events: clear and, separately, asynchronous reset after 5 accepts -> all state zeroed; enable=0 during the tick -> no pulse and counter held.
